// File: rtl/crc_dec_pkg.sv
// rtl/crc_dec_pkg.sv - shared CRC polynomial arithmetic for the decoder family
package crc_dec_pkg;

    localparam int MAX_W      = 256;
    localparam int MAX_C      = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_CRC_W  = 8;
    localparam int DEF_N      = DEF_DATA_W + DEF_CRC_W;

    typedef logic [MAX_W-1:0] vec_t;
    typedef logic [MAX_C-1:0] rem_t;
    typedef logic [MAX_C:0]   acc_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // v(x) mod G, G = x^cw + poly; only the low n bits of v are meaningful
    function automatic rem_t crc_rem(input vec_t v, input int n, input rem_t poly, input int cw);
        acc_t r;
        r = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < n) begin
                r = {r[MAX_C-1:0], v[i]};
                if (r[cw[5:0]]) r = r ^ ({1'b0, poly} | (acc_t'(1) << cw));
            end
        end
        return r[MAX_C-1:0];
    endfunction

    // x^j mod G, the syndrome produced by an error in bit j alone
    function automatic rem_t col_syndrome(input int j, input rem_t poly, input int cw);
        acc_t r;
        r = acc_t'(1);
        for (int k = 0; k < j; k++) begin
            r = r << 1;
            if (r[cw[5:0]]) r = r ^ ({1'b0, poly} | (acc_t'(1) << cw));
        end
        return r[MAX_C-1:0];
    endfunction

    // Columns stay distinct while x^j != 1 for 0 < j < n
    function automatic bit period_ok(input int n, input rem_t poly, input int cw);
        bit ok;
        ok = poly[0];
        for (int j = 1; j < n; j++) begin
            if (col_syndrome(j, poly, cw) == rem_t'(1)) ok = 1'b0;
        end
        return ok;
    endfunction

    // G(1) == 0 exactly when the non-leading terms have odd weight
    function automatic bit has_x1_factor(input rem_t poly);
        return ^poly;
    endfunction

endpackage

// File: rtl/crc_syndrome.sv
// rtl/crc_syndrome.sv - combinational codeword to syndrome reduction (code(x) mod G)
module crc_syndrome
    import crc_dec_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY = 8'h07
) (
    input  logic [N-1:0]     code,
    output logic [CRC_W-1:0] syndrome
);

    assign syndrome = CRC_W'(crc_rem(vec_t'(code), N, rem_t'(POLY), CRC_W));

endmodule

// File: rtl/crc_dec_stream.sv
// rtl/crc_dec_stream.sv - two-stage pipelined CRC decoder with single-bit correction and error counters
module crc_dec_stream
    import crc_dec_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h07,
    parameter int CNT_W = 16,
    localparam int N = DATA_W + CRC_W,
    localparam int PW = clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [N-1:0]      i_code,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CRC_W-1:0]  o_syndrome,
    output logic [PW-1:0]     o_err_pos,
    output logic              o_err_detec,
    output logic              o_err_corr,
    output logic              o_err_fatal,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_cnt_corr,
    output logic [CNT_W-1:0]  o_cnt_fatal
);

    if (N > MAX_W || CRC_W > MAX_C) begin : g_bad_size
        $error("crc_dec_stream: codeword or check width exceeds package limits");
    end
    if (!period_ok(N, rem_t'(POLY), CRC_W)) begin : g_bad_period
        $error("crc_dec_stream: codeword longer than the period of POLY");
    end
    if (!has_x1_factor(rem_t'(POLY))) begin : g_bad_parity
        $error("crc_dec_stream: generator lacks the (x+1) factor");
    end

    function automatic logic [N*CRC_W-1:0] build_cols();
        logic [N*CRC_W-1:0] t;
        for (int j = 0; j < N; j++) begin
            t[j*CRC_W +: CRC_W] = CRC_W'(col_syndrome(j, rem_t'(POLY), CRC_W));
        end
        return t;
    endfunction

    localparam logic [N*CRC_W-1:0] COLS = build_cols();

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CRC_W-1:0]  s1_syn;
    logic [CRC_W-1:0]  in_syn;
    logic              s1_adv;
    logic              s2_adv;
    logic              hit;
    logic [PW-1:0]     pos;
    logic [DATA_W-1:0] fixed_data;
    logic              out_xfer;

    crc_syndrome #(.N(N), .CRC_W(CRC_W), .POLY(POLY)) u_syn (
        .code     (i_code),
        .syndrome (in_syn)
    );

    assign s2_adv   = enable & (~o_valid | o_ready);
    assign s1_adv   = s2_adv | (enable & ~s1_valid);
    assign i_ready  = reset_n & s1_adv;
    assign out_xfer = enable & o_valid & o_ready;

    // Column syndromes are distinct and nonzero, so at most one position matches
    always_comb begin
        hit        = 1'b0;
        pos        = '0;
        fixed_data = s1_data;
        for (int j = 0; j < CRC_W; j++) begin
            if (s1_syn == COLS[j*CRC_W +: CRC_W]) begin
                hit = 1'b1;
                pos = PW'(j);
            end
        end
        for (int j = 0; j < DATA_W; j++) begin
            if (s1_syn == COLS[(j+CRC_W)*CRC_W +: CRC_W]) begin
                hit           = 1'b1;
                pos           = PW'(j + CRC_W);
                fixed_data[j] = ~s1_data[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_syn      <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_syndrome  <= '0;
            o_err_pos   <= '0;
            o_err_detec <= 1'b0;
            o_err_corr  <= 1'b0;
            o_err_fatal <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= i_valid;
                s1_data  <= i_code[N-1:CRC_W];
                s1_syn   <= in_syn;
            end
            if (s2_adv) begin
                o_valid     <= s1_valid;
                o_data      <= fixed_data;
                o_syndrome  <= s1_syn;
                o_err_pos   <= pos;
                o_err_detec <= |s1_syn;
                o_err_corr  <= hit;
                o_err_fatal <= (|s1_syn) & ~hit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_cnt_corr  <= '0;
            o_cnt_fatal <= '0;
        end else if (enable) begin
            if (i_cnt_clr) begin
                o_cnt_corr  <= '0;
                o_cnt_fatal <= '0;
            end else begin
                if (out_xfer && o_err_corr && !(&o_cnt_corr))
                    o_cnt_corr <= o_cnt_corr + CNT_W'(1);
                if (out_xfer && o_err_fatal && !(&o_cnt_fatal))
                    o_cnt_fatal <= o_cnt_fatal + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_crc_dec_stream.sv
// tb/tb_crc_dec_stream.sv - randomized and directed bench for crc_dec_stream against a brute-force model
module tb_crc_dec_stream;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int N    = DW + CW;
    localparam int PW   = 7;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;
    localparam logic [CW-1:0] G = 8'h07;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic            i_valid = 1'b0;
    logic            i_ready;
    logic [N-1:0]    i_code = '0;
    logic            o_valid;
    logic            o_ready = 1'b0;
    logic [DW-1:0]   o_data;
    logic [CW-1:0]   o_syndrome;
    logic [PW-1:0]   o_err_pos;
    logic            o_err_detec;
    logic            o_err_corr;
    logic            o_err_fatal;
    logic            i_cnt_clr = 1'b0;
    logic [CNTW-1:0] o_cnt_corr;
    logic [CNTW-1:0] o_cnt_fatal;

    crc_dec_stream #(.DATA_W(DW), .CRC_W(CW), .POLY(G), .CNT_W(CNTW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_code      (i_code),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_syndrome  (o_syndrome),
        .o_err_pos   (o_err_pos),
        .o_err_detec (o_err_detec),
        .o_err_corr  (o_err_corr),
        .o_err_fatal (o_err_fatal),
        .i_cnt_clr   (i_cnt_clr),
        .o_cnt_corr  (o_cnt_corr),
        .o_cnt_fatal (o_cnt_fatal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] syn;
        logic [PW-1:0] pos;
        logic          detec;
        logic          corr;
        logic          fatal;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mcorr = 0;
    int   mfatal = 0;
    int   n_pop = 0;
    logic last_ready;
    logic acc_f;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard MSB-first CRC of the payload: data(x)*x^CW mod G
    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] r;
        logic fb;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = r[CW-1] ^ d[i];
            r  = r << 1;
            if (fb) r = r ^ G;
        end
        return r;
    endfunction

    function automatic bit is_cw(input logic [N-1:0] c);
        return enc(c[N-1:CW]) == c[CW-1:0];
    endfunction

    // Syndrome by linearity; correction by trying every single-bit flip
    function automatic exp_t model(input logic [N-1:0] c);
        exp_t e;
        logic [N-1:0] t;
        e.syn   = enc(c[N-1:CW]) ^ c[CW-1:0];
        e.detec = (e.syn != 0);
        e.corr  = 1'b0;
        e.fatal = 1'b0;
        e.pos   = '0;
        e.data  = c[N-1:CW];
        if (e.detec) begin
            for (int j = 0; j < N; j++) begin
                t = c;
                t[j] = ~t[j];
                if (!e.corr && is_cw(t)) begin
                    e.corr = 1'b1;
                    e.pos  = PW'(j);
                    e.data = t[N-1:CW];
                end
            end
            e.fatal = !e.corr;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] rand_code(input int flips);
        logic [DW-1:0] d;
        logic [N-1:0] c;
        int j1, j2, j3;
        d  = {$urandom, $urandom};
        c  = {d, enc(d)};
        j1 = $urandom_range(0, N - 1);
        j2 = (j1 + 1 + $urandom_range(0, N - 2)) % N;
        j3 = $urandom_range(0, N - 1);
        if (flips >= 1) c[j1] = ~c[j1];
        if (flips >= 2) c[j2] = ~c[j2];
        if (flips >= 3) c[j3] = ~c[j3];
        return c;
    endfunction

    // Called at a falling edge; drives one cycle and checks outputs and counters
    task automatic step(input logic v, input logic [N-1:0] c, input logic ordy, input logic clr, output logic acc);
        exp_t e;
        logic xfer;
        logic have;
        i_valid   = v;
        i_code    = c;
        o_ready   = ordy;
        i_cnt_clr = clr;
        #1;
        last_ready = i_ready;
        chk("cnt_corr", o_cnt_corr, mcorr);
        chk("cnt_fatal", o_cnt_fatal, mfatal);
        xfer = o_valid & o_ready & enable;
        acc  = i_valid & i_ready;
        have = 1'b0;
        if (o_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_beat", o_valid, 1'b0);
            end else begin
                e    = sbq[0];
                have = 1'b1;
                chk("data", o_data, e.data);
                chk("syndrome", o_syndrome, e.syn);
                chk("err_pos", o_err_pos, e.pos);
                chk("err_detec", o_err_detec, e.detec);
                chk("err_corr", o_err_corr, e.corr);
                chk("err_fatal", o_err_fatal, e.fatal);
                if (xfer) begin
                    void'(sbq.pop_front());
                    n_pop++;
                end
            end
        end
        if (enable && reset_n) begin
            if (clr) begin
                mcorr  = 0;
                mfatal = 0;
            end else if (xfer && have) begin
                if (e.corr && mcorr < CMAX) mcorr++;
                if (e.fatal && mfatal < CMAX) mfatal++;
            end
        end
        if (acc) sbq.push_back(model(c));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sbq.size() > 0; t++) step(1'b0, '0, 1'b1, 1'b0, acc_f);
        chk("drain_left", sbq.size(), 0);
    endtask

    task automatic send(input logic [N-1:0] c);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) step(1'b1, c, 1'b1, 1'b0, ok);
        chk("send_accept", ok, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [N-1:0] c, input logic [CW-1:0] syn,
                            input int pos, input logic corr, input logic fatal, input logic [DW-1:0] data);
        logic acc;
        step(1'b1, c, 1'b0, 1'b0, acc);
        chk({tag, "_accept"}, acc, 1'b1);
        chk({tag, "_lat1"}, o_valid, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        chk({tag, "_lat2"}, o_valid, 1'b1);
        chk({tag, "_data"}, o_data, data);
        chk({tag, "_syn"}, o_syndrome, syn);
        chk({tag, "_pos"}, o_err_pos, pos);
        chk({tag, "_detec"}, o_err_detec, syn != 0);
        chk({tag, "_corr"}, o_err_corr, corr);
        chk({tag, "_fatal"}, o_err_fatal, fatal);
        step(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic [N-1:0] beats [4];
        logic [N-1:0] code;
        int idx;
        int pop0;
        logic saw_block;

        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_o_data", o_data, 0);
        chk("rst_flags", {o_err_detec, o_err_corr, o_err_fatal}, 3'b000);
        chk("rst_cnt", {o_cnt_corr, o_cnt_fatal}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        directed("clean", 72'h0, 8'h00, 0, 1'b0, 1'b0, 64'h0);
        directed("dbit0", 72'h100, 8'h07, 8, 1'b1, 1'b0, 64'h0);
        chk("dbit0_cnt_corr", o_cnt_corr, 1);
        directed("cbit0", 72'h1, 8'h01, 0, 1'b1, 1'b0, 64'h0);
        chk("cbit0_cnt_corr", o_cnt_corr, 2);
        directed("double", 72'h300, 8'h09, 0, 1'b0, 1'b1, 64'h3);
        chk("double_cnt_fatal", o_cnt_fatal, 1);

        for (int k = 0; k < 4; k++) beats[k] = rand_code(k % 2);
        idx = 0;
        pop0 = n_pop;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 30 && idx < 4; cyc++) begin
            step(1'b1, beats[idx], !(cyc >= 2 && cyc < 5), 1'b0, acc_f);
            if (last_ready === 1'b0) saw_block = 1'b1;
            if (acc_f) idx++;
        end
        drain();
        chk("bp_all_sent", idx, 4);
        chk("bp_ready_dropped", saw_block, 1'b1);
        chk("bp_beats_out", n_pop - pop0, 4);

        for (int k = 0; k < 300; k++) begin
            logic ok;
            code = rand_code($urandom_range(0, 3));
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) step(1'b1, code, $urandom_range(0, 3) != 0, 1'b0, ok);
            chk("rand_accept", ok, 1'b1);
            if ($urandom_range(0, 3) == 0) step(1'b0, '0, $urandom_range(0, 1) != 0, 1'b0, acc_f);
        end
        drain();

        step(1'b1, rand_code(1), 1'b0, 1'b0, acc_f);
        step(1'b0, '0, 1'b0, 1'b0, acc_f);
        enable = 1'b0;
        step(1'b1, rand_code(0), 1'b1, 1'b0, acc_f);
        chk("en0_no_accept", acc_f, 1'b0);
        chk("en0_valid_held", o_valid, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, acc_f);
        chk("en0_valid_held2", o_valid, 1'b1);
        enable = 1'b1;
        drain();

        step(1'b0, '0, 1'b1, 1'b1, acc_f);
        for (int k = 0; k < (1 << CNTW) + 2; k++) send(rand_code(1));
        drain();
        chk("sat_cnt_corr", o_cnt_corr, 15);
        step(1'b1, rand_code(1), 1'b0, 1'b0, acc_f);
        step(1'b0, '0, 1'b0, 1'b0, acc_f);
        chk("clr_pending_corr", o_err_corr, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, acc_f);
        chk("clr_beats_cnt", o_cnt_corr, 0);

        send(rand_code(1));
        send(rand_code(2));
        reset_n = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_i_ready", i_ready, 1'b0);
        chk("midrst_cnt", {o_cnt_corr, o_cnt_fatal}, 0);
        sbq.delete();
        mcorr = 0;
        mfatal = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0, acc_f);
        chk("midrst_no_output", o_valid, 1'b0);
        send(72'h100);
        drain();
        chk("post_rst_cnt_corr", o_cnt_corr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc_dec_stream.md
Name: crc_dec_stream

Overview:
- Parametrised, pipelined successor to the fixed 64-bit CRC decoder.
- Accepts a {data, crc} codeword per beat over a valid/ready handshake, computes the CRC syndrome, and corrects any single-bit error (data or check bit).
- Flags detected-but-uncorrectable words and keeps saturating error statistics.
- Sits between the memory/link read path and the consumer.

Parameters:
DATA_W, 64, payload width in bits
CRC_W, 8, check width in bits
POLY, 8'h07, generator polynomial without the x^CRC_W term (CRC-8: x^8+x^2+x+1)
CNT_W, 16, width of each error counter
Constraints:
- N = DATA_W+CRC_W must be ≤ period of POLY (127 for default).
- Generator must contain factor (x+1).
- Both are checked by elaboration assertion.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run; 0 freezes pipeline, counters and i_ready
i_valid  in  1  input codeword valid
i_ready  out  1  decoder can accept
i_code  in  N  codeword; bit i = coefficient of x^i; [N-1:CRC_W]=data, [CRC_W-1:0]=crc
o_valid  out  1  output beat valid
o_ready  in  1  consumer accepts
o_data  out  DATA_W  corrected data
o_syndrome  out  CRC_W  raw syndrome of the beat
o_err_pos  out  clog2(N)  flipped bit index; 0 when no correction
o_err_detec  out  1  syndrome nonzero
o_err_corr  out  1  single-bit error corrected
o_err_fatal  out  1  nonzero syndrome matching no single position; data passed uncorrected
i_cnt_clr  in  1  synchronous clear of counters
o_cnt_corr  out  CNT_W  corrected-word count
o_cnt_fatal  out  CNT_W  fatal-word count

Behaviour:
- Reset (reset_n=0, asynchronous): all pipeline valids=0, all outputs and counters=0, i_ready=0 while in reset.
- Codeword definition:
  - crc = (data·x^CRC_W) mod G.
  - MSB-first, zero init, no reflection, no xor-out.
- Stage S1 (on accept): register code and syndrome S = code(x) mod G.
- Stage S2: compare S against column syndromes C[j] = x^j mod G, j=0..N-1 (constants).
  - S=0: clean.
  - S==C[j]: flip bit j, err_corr=1, err_pos=j.
  - Else: err_fatal=1, data unmodified.
  - err_detec = (S!=0).
  - Double errors always give an even-weight S and never miscorrect.
- Latency: 2 cycles from accept to o_valid with no backpressure; throughput 1 word/cycle.
- Handshake:
  - Transfer on valid&ready.
  - S2 advances when ~s2_valid | o_ready.
  - S1 advances when S2 advances or ~s1_valid.
  - i_ready = enable & S1-advance (combinational, no skid buffer).
  - o_valid and all o_* are held stable while o_valid & ~o_ready.
- enable=0:
  - No stage moves.
  - o_valid holds its value; an outstanding beat may still complete on o_ready only if enable=1.
  - Counters hold.
- Counters:
  - Increment on output transfer with the matching flag.
  - Saturate at 2^CNT_W-1.
  - i_cnt_clr wins over a same-cycle increment.
- Reset mid-operation: in-flight beats are discarded, with no output.

Decomposition:
- crc_dec_pkg:
  - function crc_rem(vector, POLY, CRC_W);
  - function col_syndrome(j);
  - clog2 helper;
  - localparam N.
- Sub-module crc_syndrome: combinational code → syndrome, reused by the future encoder. Instantiated once in S1.

Test Plan:
- i_code=72'h0 → after 2 cycles o_valid=1, o_data=0, syndrome 0, all flags 0.
- i_code=72'h100 (data bit 0 flipped) → syndrome 8'h07, err_corr=1, err_pos=8, o_data=64'h0, cnt_corr=1.
- i_code=72'h1 (crc bit 0 flipped) → syndrome 8'h01, err_corr=1, err_pos=0, o_data=0.
- i_code=72'h300 (two data bits) → syndrome 8'h09, err_fatal=1, err_detec=1, o_data=64'h3, cnt_fatal=1.
- Stream 4 beats with o_ready low for 3 cycles mid-stream → i_ready drops once both stages are full, outputs stay stable, no beat lost or duplicated, order preserved.
- Force 2^CNT_W+2 correctable beats (CNT_W=4 override) → cnt_corr saturates at 15; assert i_cnt_clr together with a correctable beat → counter reads 0.
